// File: rtl/disp_scan_if.sv
// Bundle between a display source and the seven-segment scan controller.
// The source drives value, masks and brightness. The controller returns the pin-level drive.
interface disp_scan_if;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [2:0]  bright;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    modport master (
        output digits, dp_in, blank, bright,
        input  seg, an, dp, frame_start
    );

    modport slave (
        input  digits, dp_in, blank, bright,
        output seg, an, dp, frame_start
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// It captures inputs once per frame, applies PWM brightness, and drives registered active-low pins.
module disp_scan_ctrl #(
    parameter int SUB_DIV = 12500
) (
    input  logic        clk,
    input  logic        rst,
    disp_scan_if.slave  bus
);
    localparam int SUB_W = $clog2(SUB_DIV);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [2:0]       phase_q, phase_d;
    logic [1:0]       digit_q, digit_d;
    logic             init_q, init_d;

    logic [15:0] digits_sh_q, digits_sh_d;
    logic [3:0]  dp_sh_q, dp_sh_d;
    logic [3:0]  blank_sh_q, blank_sh_d;
    logic [2:0]  bright_sh_q, bright_sh_d;

    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic       dp_q, dp_d;
    logic       frame_start_q, frame_start_d;

    logic sub_wrap, phase_wrap, capture;
    logic [3:0] nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        sub_wrap   = (sub_q == SUB_LAST);
        phase_wrap = sub_wrap && (phase_q == 3'd7);
        sub_d      = sub_wrap ? '0 : sub_q + SUB_W'(1);
        phase_d    = phase_q + {2'b00, sub_wrap};
        digit_d    = digit_q + {1'b0, phase_wrap};

        // The first edge out of reset loads the shadows so the display does not wait a full frame.
        capture = init_q || (phase_wrap && (digit_q == 2'd3));
        init_d  = 1'b0;

        digits_sh_d = capture ? bus.digits : digits_sh_q;
        dp_sh_d     = capture ? bus.dp_in  : dp_sh_q;
        blank_sh_d  = capture ? bus.blank  : blank_sh_q;
        bright_sh_d = capture ? bus.bright : bright_sh_q;

        nibble = digits_sh_q[{digit_q, 2'b00} +: 4];
        seg_d  = hex7(nibble);
        dp_d   = ~dp_sh_q[digit_q];
        an_d   = 4'hF;
        if (!blank_sh_q[digit_q] && (phase_q <= bright_sh_q))
            an_d[digit_q] = 1'b0;
        frame_start_d = capture;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q         <= '0;
            phase_q       <= '0;
            digit_q       <= '0;
            init_q        <= 1'b1;
            digits_sh_q   <= '0;
            dp_sh_q       <= '0;
            blank_sh_q    <= 4'hF;
            bright_sh_q   <= '0;
            seg_q         <= 7'h7F;
            an_q          <= 4'hF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            sub_q         <= sub_d;
            phase_q       <= phase_d;
            digit_q       <= digit_d;
            init_q        <= init_d;
            digits_sh_q   <= digits_sh_d;
            dp_sh_q       <= dp_sh_d;
            blank_sh_q    <= blank_sh_d;
            bright_sh_q   <= bright_sh_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SUB_DIV=2.
// Slot = 16 cycles, frame = 64 cycles. The output seen after edge En reflects count n.
module tb_disp_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    disp_scan_if bus();

    disp_scan_ctrl #(.SUB_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Holds reset, loads inputs, releases, and returns at the negedge after E0 (n=0).
    task automatic start(input logic [15:0] d, input logic [3:0] dpv,
                         input logic [3:0] bl, input logic [2:0] br);
        @(negedge clk);
        rst = 1'b1;
        bus.digits = d; bus.dp_in = dpv; bus.blank = bl; bus.bright = br;
        step; step;
        rst = 1'b0;
        step;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        bus.digits = 16'h3210; bus.dp_in = 4'h0; bus.blank = 4'h0; bus.bright = 3'd7;
        step;
        n_vec++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL rst_seg got %b want %b", bus.seg, 7'h7F); end
        n_vec++; if (bus.an !== 4'hF) begin n_err++; $display("FAIL rst_an got %b want %b", bus.an, 4'hF); end
        n_vec++; if (bus.dp !== 1'b1) begin n_err++; $display("FAIL rst_dp got %b want 1", bus.dp); end
        n_vec++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs got %b want 0", bus.frame_start); end
        rst = 1'b0;
        step;
        n_vec++; if (bus.frame_start !== 1'b1) begin n_err++; $display("FAIL e0_fs got %b want 1", bus.frame_start); end
        n_vec++; if (bus.an !== 4'hF) begin n_err++; $display("FAIL e0_an got %b want 1111", bus.an); end
        step;
        n_vec++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL e1_fs got %b want 0", bus.frame_start); end
        n_vec++; if (bus.an !== 4'b1110) begin n_err++; $display("FAIL e1_an got %b want 1110", bus.an); end
        n_vec++; if (bus.seg !== HEX_TAB[0]) begin n_err++; $display("FAIL e1_seg got %b want %b", bus.seg, HEX_TAB[0]); end
    endtask

    task automatic test_scan;
        logic [15:0] dg;
        logic [3:0]  one, exp_an, nib;
        logic        exp_fs;
        int          d;
        dg = 16'h3210;
        start(dg, 4'h0, 4'h0, 3'd7);
        for (int n = 1; n <= 140; n++) begin
            step;
            d      = (n / 16) % 4;
            one    = 4'b0001 << d;
            exp_an = ~one;
            nib    = 4'((dg >> (4 * d)) & 16'hF);
            exp_fs = ((n % 64) == 63);
            n_vec++; if (bus.an !== exp_an) begin n_err++; $display("FAIL scan_an n=%0d got %b want %b", n, bus.an, exp_an); end
            n_vec++; if (bus.seg !== HEX_TAB[nib]) begin n_err++; $display("FAIL scan_seg n=%0d got %b want %b", n, bus.seg, HEX_TAB[nib]); end
            n_vec++; if (bus.frame_start !== exp_fs) begin n_err++; $display("FAIL scan_fs n=%0d got %b want %b", n, bus.frame_start, exp_fs); end
        end
    endtask

    task automatic test_brightness;
        logic [3:0] one, exp_an;
        int         d, pos;
        start(16'h3210, 4'h0, 4'h0, 3'd2);
        for (int n = 1; n <= 80; n++) begin
            step;
            d      = (n / 16) % 4;
            pos    = n % 16;
            one    = 4'b0001 << d;
            exp_an = (pos < 6) ? ~one : 4'hF;
            n_vec++; if (bus.an !== exp_an) begin n_err++; $display("FAIL bright_an n=%0d got %b want %b", n, bus.an, exp_an); end
        end
    endtask

    task automatic test_frame_atomic;
        logic [6:0] exp_seg;
        start(16'h0000, 4'h0, 4'h0, 3'd7);
        for (int n = 1; n <= 130; n++) begin
            step;
            exp_seg = (n < 64) ? HEX_TAB[0] : HEX_TAB[15];
            n_vec++; if (bus.seg !== exp_seg) begin n_err++; $display("FAIL atomic_seg n=%0d got %b want %b", n, bus.seg, exp_seg); end
            if (n == 20) bus.digits = 16'hFFFF;
        end
    endtask

    task automatic test_blank_dp;
        logic [3:0] bl, dpv, one, exp_an;
        logic       exp_dp;
        int         d;
        bl  = 4'b0101;
        dpv = 4'b0010;
        start(16'h3210, dpv, bl, 3'd7);
        for (int n = 1; n <= 70; n++) begin
            step;
            d      = (n / 16) % 4;
            one    = 4'b0001 << d;
            exp_an = bl[d] ? 4'hF : ~one;
            exp_dp = ~dpv[d];
            n_vec++; if (bus.an !== exp_an) begin n_err++; $display("FAIL blank_an n=%0d got %b want %b", n, bus.an, exp_an); end
            n_vec++; if (bus.dp !== exp_dp) begin n_err++; $display("FAIL blank_dp n=%0d got %b want %b", n, bus.dp, exp_dp); end
        end
    endtask

    task automatic test_midframe_reset;
        start(16'h3210, 4'h1, 4'h0, 3'd7);
        for (int n = 1; n <= 40; n++) step;
        n_vec++; if (bus.an !== 4'b1011) begin n_err++; $display("FAIL mid_pre_an got %b want 1011", bus.an); end
        rst = 1'b1;
        bus.digits = 16'h0005;
        step;
        n_vec++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL mid_seg got %b want 1111111", bus.seg); end
        n_vec++; if (bus.an !== 4'hF) begin n_err++; $display("FAIL mid_an got %b want 1111", bus.an); end
        n_vec++; if (bus.dp !== 1'b1) begin n_err++; $display("FAIL mid_dp got %b want 1", bus.dp); end
        n_vec++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL mid_fs got %b want 0", bus.frame_start); end
        rst = 1'b0;
        step;
        n_vec++; if (bus.frame_start !== 1'b1) begin n_err++; $display("FAIL mid_e0_fs got %b want 1", bus.frame_start); end
        step;
        n_vec++; if (bus.an !== 4'b1110) begin n_err++; $display("FAIL mid_e1_an got %b want 1110", bus.an); end
        n_vec++; if (bus.seg !== HEX_TAB[5]) begin n_err++; $display("FAIL mid_e1_seg got %b want %b", bus.seg, HEX_TAB[5]); end
        n_vec++; if (bus.dp !== 1'b0) begin n_err++; $display("FAIL mid_e1_dp got %b want 0", bus.dp); end
    endtask

    task automatic test_hex_sweep;
        int n;
        n = 0;
        start(16'h0000, 4'h0, 4'h0, 3'd7);
        for (int f = 0; f < 16; f++) begin
            while (n < 64 * f + 5) begin
                step;
                n++;
            end
            n_vec++; if (bus.seg !== HEX_TAB[f]) begin n_err++; $display("FAIL sweep_seg v=%0d got %b want %b", f, bus.seg, HEX_TAB[f]); end
            n_vec++; if (bus.an !== 4'b1110) begin n_err++; $display("FAIL sweep_an v=%0d got %b want 1110", f, bus.an); end
            bus.digits = 16'(f + 1);
        end
    endtask

    initial begin
        bus.digits = 16'h0; bus.dp_in = 4'h0; bus.blank = 4'h0; bus.bright = 3'd0;
        test_reset;
        test_scan;
        test_brightness;
        test_frame_atomic;
        test_blank_dp;
        test_midframe_reset;
        test_hex_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
